fetch_line_unit: RTL and testbench

- Parametrised next-generation instruction fetch front end.
- Holds the PC and an N-entry fully associative line buffer; misses go to the I-cache as full-line reads.
- Delivers one instruction per cycle, with PC and order tag, into the instruction queue.
- Adds what the single-entry fetch lacked: multiple buffered lines, round-robin replacement, redirect/flush with squash of an in-flight miss.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_line_buffer.sv | 57 +++++
 rtl/fetch_line_unit.sv | 121 ++++++++++++
 tb/tb_fetch_line_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and geometry helpers for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Byte-offset bits within one I-cache line.
  function automatic int ofs_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  // Bits needed to select one 32-bit word within a line.
  function automatic int widx_bits(input int line_bits);
    return $clog2(line_bits / 32);
  endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: fully associative buffer of I-cache lines with a
// round-robin fill pointer. Valid bits clear asynchronously on rst.
module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter  int LB_ENTRIES = 4,
  parameter  int LINE_BITS  = 256,
  localparam int OFS        = ofs_bits(LINE_BITS),
  localparam int TAG_W      = 32 - OFS,
  localparam int IDX_W      = widx_bits(LINE_BITS),
  localparam int RR_W       = (LB_ENTRIES > 1) ? $clog2(LB_ENTRIES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TAG_W-1:0]     lk_tag,
  input  logic [IDX_W-1:0]     lk_idx,
  output logic                 hit,
  output logic [31:0]          word,
  input  logic                 fill_en,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line
);

  // Entry layout depends on the line geometry, so it is declared per instance.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] line;
  } lb_entry_t;

  lb_entry_t       ent [LB_ENTRIES];
  logic [RR_W-1:0] rr;

  // Fill the entry under rr and advance the pointer, wrapping at LB_ENTRIES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LB_ENTRIES; i++) ent[i] <= '0;
      rr <= '0;
    end else if (fill_en) begin
      ent[rr] <= '{valid: 1'b1, tag: fill_tag, line: fill_line};
      rr      <= (rr == RR_W'(LB_ENTRIES - 1)) ? '0 : rr + 1'b1;
    end
  end

  // Tag compare across all entries; tags are unique so OR-merging words is safe.
  always_comb begin
    hit  = 1'b0;
    word = '0;
    for (int i = 0; i < LB_ENTRIES; i++) begin
      if (ent[i].valid && ent[i].tag == lk_tag) begin
        hit  = 1'b1;
        word = word | ent[i].line[32*lk_idx +: 32];
      end
    end
  end

endmodule

// File: rtl/fetch_line_unit.sv
// fetch_line_unit: instruction fetch front end. Holds the PC, looks it up in
// a multi-line buffer, issues full-line I-cache reads on a miss and enqueues
// one instruction per cycle. Redirects squash an outstanding miss via DRAIN.
// Optional build macro FETCH_PERF_CTR_EN adds saturating hit/miss counters.
module fetch_line_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'haaaaa000,
  parameter int          LINE_BITS  = 256,
  parameter int          LB_ENTRIES = 4,
  parameter int          ORDER_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          icache_addr,
  output logic [3:0]           icache_rmask,
  input  logic [LINE_BITS-1:0] icache_rdata,
  input  logic                 icache_resp,
  input  logic                 iq_full,
  output logic                 iq_enqueue,
  output logic [31:0]          iq_instr,
  output logic [31:0]          iq_pc,
  output logic [ORDER_W-1:0]   iq_order
`ifdef FETCH_PERF_CTR_EN
  ,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
`endif
);

  localparam int OFS   = ofs_bits(LINE_BITS);
  localparam int TAG_W = 32 - OFS;
  localparam int IDX_W = widx_bits(LINE_BITS);

  fetch_state_t       state;
  logic [31:0]        pc;
  logic [ORDER_W-1:0] order;
  logic               lb_hit;
  logic [31:0]        lb_word;
  logic               fill_en;

  // A response is only meaningful while a read is outstanding (MISS or DRAIN).
  assign fill_en = (state != RUN) && icache_resp;

  fetch_line_buffer #(
    .LB_ENTRIES (LB_ENTRIES),
    .LINE_BITS  (LINE_BITS)
  ) u_lb (
    .clk       (clk),
    .rst       (rst),
    .lk_tag    (pc[31:OFS]),
    .lk_idx    (pc[OFS-1:2]),
    .hit       (lb_hit),
    .word      (lb_word),
    .fill_en   (fill_en),
    .fill_tag  (icache_addr[31:OFS]),
    .fill_line (icache_rdata)
  );

  // Fetch control: redirect first, then hit/enqueue or miss issue in RUN.
  // The fill tag comes from icache_addr, which stays put even after a
  // redirect has moved pc away from the squashed line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      order        <= '0;
      icache_addr  <= '0;
      icache_rmask <= 4'h0;
      iq_enqueue   <= 1'b0;
      iq_instr     <= '0;
      iq_pc        <= '0;
      iq_order     <= '0;
    end else begin
      iq_enqueue <= 1'b0;
      if (fill_en) begin
        icache_rmask <= 4'h0;
        state        <= RUN;
      end
      if (redirect_valid) begin
        pc <= redirect_pc & 32'hFFFF_FFFC;
        if (state == MISS && !icache_resp) state <= DRAIN;
      end else if (state == RUN) begin
        if (lb_hit) begin
          if (!iq_full) begin
            iq_enqueue <= 1'b1;
            iq_instr   <= lb_word;
            iq_pc      <= pc;
            iq_order   <= order;
            pc         <= pc + 32'd4;
            order      <= order + 1'b1;
          end
        end else begin
          icache_addr  <= {pc[31:OFS], {OFS{1'b0}}};
          icache_rmask <= 4'hF;
          state        <= MISS;
        end
      end
    end
  end

`ifdef FETCH_PERF_CTR_EN
  logic enq_fire, miss_fire;
  assign enq_fire  = (state == RUN) && !redirect_valid && lb_hit && !iq_full;
  assign miss_fire = (state == RUN) && !redirect_valid && !lb_hit;

  // Saturating event counters for enqueues and RUN->MISS transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (enq_fire && perf_hits != '1)    perf_hits   <= perf_hits + 1'b1;
      if (miss_fire && perf_misses != '1) perf_misses <= perf_misses + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_line_unit.sv
// tb_fetch_line_unit: directed bench for fetch_line_unit with a line-returning
// I-cache responder and a monitor that logs enqueues and read issues.
module tb_fetch_line_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic [31:0]  icache_addr;
  logic [3:0]   icache_rmask;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic         iq_full = 1'b0;
  logic         iq_enqueue;
  logic [31:0]  iq_instr;
  logic [31:0]  iq_pc;
  logic [63:0]  iq_order;
`ifdef FETCH_PERF_CTR_EN
  logic [31:0]  perf_hits;
  logic [31:0]  perf_misses;
`endif

  int checks = 0;
  int failures = 0;

  fetch_line_unit #(
    .RESET_PC   (32'haaaaa000),
    .LINE_BITS  (256),
    .LB_ENTRIES (4),
    .ORDER_W    (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_addr    (icache_addr),
    .icache_rmask   (icache_rmask),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .iq_full        (iq_full),
    .iq_enqueue     (iq_enqueue),
    .iq_instr       (iq_instr),
    .iq_pc          (iq_pc),
    .iq_order       (iq_order)
`ifdef FETCH_PERF_CTR_EN
    ,
    .perf_hits      (perf_hits),
    .perf_misses    (perf_misses)
`endif
  );

  always #5 clk = ~clk;

  // Line contents: word i of the line at address a holds ~(a + 4*i).
  function automatic logic [255:0] make_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = ~(a + 32'(4 * i));
    return l;
  endfunction

  // Responder: answers an outstanding read resp_lat cycles after issue.
  int           resp_lat = 3;
  bit           resp_en = 1'b0;
  logic         resp_auto = 1'b0;
  logic         resp_force = 1'b0;
  logic [255:0] rdata_auto = '0;
  int           rcnt = 0;
  assign icache_resp  = resp_auto | resp_force;
  assign icache_rdata = resp_force ? {8{32'h0BADF00D}} : rdata_auto;

  always @(posedge clk) begin
    #2;
    resp_auto = 1'b0;
    if (rst || icache_rmask != 4'hF || !resp_en) rcnt = 0;
    else begin
      rcnt++;
      if (rcnt == resp_lat) begin
        resp_auto  = 1'b1;
        rdata_auto = make_line(icache_addr);
        rcnt       = 0;
      end
    end
  end

  // Monitor: log every enqueue and every rising edge of the read mask.
  logic [31:0] enq_pc[$];
  logic [31:0] enq_instr[$];
  logic [63:0] enq_order[$];
  logic [31:0] rd_addr[$];
  logic        rmask_q = 1'b0;

  always @(posedge clk) begin
    #1;
    if (iq_enqueue) begin
      enq_pc.push_back(iq_pc);
      enq_instr.push_back(iq_instr);
      enq_order.push_back(iq_order);
    end
    if (icache_rmask == 4'hF && !rmask_q) rd_addr.push_back(icache_addr);
    rmask_q = (icache_rmask == 4'hF);
  end

  int eb = 0;  // enqueue log index at start of the current test
  int rb = 0;  // read log index at start of the current test

  task automatic do_reset;
    rst = 1'b1; resp_en = 1'b0; resp_force = 1'b0; iq_full = 1'b0;
    redirect_valid = 1'b0; resp_lat = 3;
    repeat (2) @(negedge clk);
    eb = enq_pc.size(); rb = rd_addr.size();
    rst = 1'b0;
  endtask

  task automatic wait_enq(input int n, input int budget);
    int k = 0;
    while (enq_pc.size() - eb < n && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (enq_pc.size() - eb < n) begin
      failures++;
      $display("FAIL wait_enq: got %0d enqueues, want %0d", enq_pc.size() - eb, n);
    end
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k = 0;
    while (rd_addr.size() - rb < n && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (rd_addr.size() - rb < n) begin
      failures++;
      $display("FAIL wait_rd: got %0d reads, want %0d", rd_addr.size() - rb, n);
    end
  endtask

  task automatic wait_pc(input logic [31:0] p, input int from, input int budget, output int idx);
    int k = 0;
    idx = -1;
    while (idx < 0 && k <= budget) begin
      for (int i = eb + from; i < enq_pc.size(); i++)
        if (idx < 0 && enq_pc[i] == p) idx = i - eb;
      if (idx < 0) begin @(negedge clk); k++; end
    end
    checks++;
    if (idx < 0) begin failures++; $display("FAIL wait_pc: pc %h never enqueued, want it", p); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (icache_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", icache_addr); end
    checks++; if (icache_rmask !== 4'h0) begin failures++; $display("FAIL rst_rmask: got %h want 0", icache_rmask); end
    checks++; if (iq_enqueue !== 1'b0) begin failures++; $display("FAIL rst_enq: got %b want 0", iq_enqueue); end
    checks++; if (iq_instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h want 0", iq_instr); end
    checks++; if (iq_pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", iq_pc); end
    checks++; if (iq_order !== 64'h0) begin failures++; $display("FAIL rst_order: got %h want 0", iq_order); end
    eb = enq_pc.size(); rb = rd_addr.size();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (icache_rmask !== 4'hF) begin failures++; $display("FAIL rst_first_rmask: got %h want f", icache_rmask); end
    checks++; if (icache_addr !== 32'haaaaa000) begin failures++; $display("FAIL rst_first_addr: got %h want aaaaa000", icache_addr); end
  endtask

  task automatic test_first_line;
    do_reset();
    resp_en = 1'b1;
    wait_enq(8, 40);
    checks++; if (rd_addr.size() - rb !== 1) begin failures++; $display("FAIL line0_reads: got %0d want 1", rd_addr.size() - rb); end
    checks++; if (rd_addr[rb] !== 32'haaaaa000) begin failures++; $display("FAIL line0_addr: got %h want aaaaa000", rd_addr[rb]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (enq_pc[eb+i] !== 32'haaaaa000 + 32'(4*i)) begin failures++; $display("FAIL line0_pc[%0d]: got %h", i, enq_pc[eb+i]); end
      checks++; if (enq_instr[eb+i] !== ~(32'haaaaa000 + 32'(4*i))) begin failures++; $display("FAIL line0_instr[%0d]: got %h", i, enq_instr[eb+i]); end
      checks++; if (enq_order[eb+i] !== 64'(i)) begin failures++; $display("FAIL line0_order[%0d]: got %0d want %0d", i, enq_order[eb+i], i); end
    end
    repeat (2) @(negedge clk);
    checks++; if (rd_addr.size() - rb !== 2) begin failures++; $display("FAIL line1_reads: got %0d want 2", rd_addr.size() - rb); end
    checks++; if (rd_addr[rb+1] !== 32'haaaaa020) begin failures++; $display("FAIL line1_addr: got %h want aaaaa020", rd_addr[rb+1]); end
  endtask

  task automatic test_stall;
    do_reset();
    resp_en = 1'b1;
    wait_enq(3, 40);
    iq_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (iq_enqueue !== 1'b0) begin failures++; $display("FAIL stall_enq[%0d]: got %b want 0", i, iq_enqueue); end
    end
    checks++; if (enq_pc.size() - eb !== 3) begin failures++; $display("FAIL stall_count: got %0d want 3", enq_pc.size() - eb); end
    checks++; if (icache_rmask !== 4'h0) begin failures++; $display("FAIL stall_rmask: got %h want 0", icache_rmask); end
    checks++; if (iq_pc !== 32'haaaaa008) begin failures++; $display("FAIL stall_iq_pc: got %h want aaaaa008", iq_pc); end
    checks++; if (rd_addr.size() - rb !== 1) begin failures++; $display("FAIL stall_reads: got %0d want 1", rd_addr.size() - rb); end
    iq_full = 1'b0;
    wait_enq(8, 20);
    checks++; if (enq_pc[eb+3] !== 32'haaaaa00c) begin failures++; $display("FAIL stall_resume_pc: got %h want aaaaa00c", enq_pc[eb+3]); end
    checks++; if (enq_order[eb+3] !== 64'd3) begin failures++; $display("FAIL stall_resume_order: got %0d want 3", enq_order[eb+3]); end
    checks++; if (enq_order[eb+7] !== 64'd7) begin failures++; $display("FAIL stall_last_order: got %0d want 7", enq_order[eb+7]); end
  endtask

  task automatic test_loop;
    int f, s;
    do_reset();
    resp_en = 1'b1;
    wait_pc(32'haaaaa040, 0, 120, f);
    redirect_valid = 1'b1; redirect_pc = 32'haaaaa000;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc(32'haaaaa040, f + 1, 60, s);
    iq_full = 1'b1;
    checks++; if (f !== 16) begin failures++; $display("FAIL loop_first_idx: got %0d want 16", f); end
    checks++; if (s !== 33) begin failures++; $display("FAIL loop_second_idx: got %0d want 33", s); end
    checks++; if (enq_pc[eb+17] !== 32'haaaaa000) begin failures++; $display("FAIL loop_target_pc: got %h want aaaaa000", enq_pc[eb+17]); end
    checks++; if (enq_order[eb+17] !== 64'd17) begin failures++; $display("FAIL loop_target_order: got %0d want 17", enq_order[eb+17]); end
    checks++; if (rd_addr.size() - rb !== 3) begin failures++; $display("FAIL loop_reads: got %0d want 3", rd_addr.size() - rb); end
    checks++; if (rd_addr[rb+2] !== 32'haaaaa040) begin failures++; $display("FAIL loop_read2: got %h want aaaaa040", rd_addr[rb+2]); end
`ifdef FETCH_PERF_CTR_EN
    checks++; if (perf_misses !== 32'd3) begin failures++; $display("FAIL perf_misses: got %0d want 3", perf_misses); end
    checks++; if (perf_hits !== 32'd34) begin failures++; $display("FAIL perf_hits: got %0d want 34", perf_hits); end
`endif
  endtask

  task automatic test_evict;
    int f, g, h;
    do_reset();
    resp_en = 1'b1;
    wait_pc(32'haaaaa080, 0, 150, f);
    redirect_valid = 1'b1; redirect_pc = 32'haaaaa020;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc(32'haaaaa020, f + 1, 20, g);
    redirect_valid = 1'b1; redirect_pc = 32'haaaaa000;
    checks++; if (g !== 33) begin failures++; $display("FAIL evict_hit_idx: got %0d want 33", g); end
    checks++; if (rd_addr.size() - rb !== 5) begin failures++; $display("FAIL evict_line1_hit: got %0d reads want 5", rd_addr.size() - rb); end
    checks++; if (rd_addr[rb+4] !== 32'haaaaa080) begin failures++; $display("FAIL evict_read4: got %h want aaaaa080", rd_addr[rb+4]); end
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc(32'haaaaa000, g + 1, 30, h);
    checks++; if (h !== 34) begin failures++; $display("FAIL evict_refetch_idx: got %0d want 34", h); end
    checks++; if (rd_addr.size() - rb !== 6) begin failures++; $display("FAIL evict_line0_miss: got %0d reads want 6", rd_addr.size() - rb); end
    checks++; if (rd_addr[rb+5] !== 32'haaaaa000) begin failures++; $display("FAIL evict_read5: got %h want aaaaa000", rd_addr[rb+5]); end
    checks++; if (enq_instr[eb+h] !== ~32'haaaaa000) begin failures++; $display("FAIL evict_instr: got %h want %h", enq_instr[eb+h], ~32'haaaaa000); end
  endtask

  task automatic test_redirect_drain;
    do_reset();
    resp_en = 1'b1; resp_lat = 5;
    wait_rd(1, 10);
    redirect_valid = 1'b1; redirect_pc = 32'haaaab003;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (icache_rmask !== 4'hF) begin failures++; $display("FAIL drain_rmask: got %h want f", icache_rmask); end
    checks++; if (icache_addr !== 32'haaaaa000) begin failures++; $display("FAIL drain_addr: got %h want aaaaa000", icache_addr); end
    wait_rd(2, 30);
    checks++; if (enq_pc.size() - eb !== 0) begin failures++; $display("FAIL drain_no_enq: got %0d want 0", enq_pc.size() - eb); end
    checks++; if (rd_addr[rb+1] !== 32'haaaab000) begin failures++; $display("FAIL drain_next_read: got %h want aaaab000", rd_addr[rb+1]); end
    wait_enq(1, 30);
    checks++; if (enq_pc[eb] !== 32'haaaab000) begin failures++; $display("FAIL drain_first_pc: got %h want aaaab000", enq_pc[eb]); end
    checks++; if (enq_instr[eb] !== ~32'haaaab000) begin failures++; $display("FAIL drain_first_instr: got %h want %h", enq_instr[eb], ~32'haaaab000); end
    checks++; if (enq_order[eb] !== 64'd0) begin failures++; $display("FAIL drain_first_order: got %0d want 0", enq_order[eb]); end
  endtask

  task automatic test_reset_mid_miss;
    int f;
    do_reset();
    resp_en = 1'b1;
    wait_pc(32'haaaaa010, 0, 40, f);
    resp_en = 1'b0;
    wait_rd(2, 20);
    checks++; if (rd_addr[rb+1] !== 32'haaaaa020) begin failures++; $display("FAIL rmm_miss_addr: got %h want aaaaa020", rd_addr[rb+1]); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (icache_rmask !== 4'h0) begin failures++; $display("FAIL rmm_rmask: got %h want 0", icache_rmask); end
    checks++; if (icache_addr !== 32'h0) begin failures++; $display("FAIL rmm_addr: got %h want 0", icache_addr); end
    checks++; if (iq_pc !== 32'h0) begin failures++; $display("FAIL rmm_iq_pc: got %h want 0", iq_pc); end
    eb = enq_pc.size(); rb = rd_addr.size();
    rst = 1'b0; resp_force = 1'b1;
    @(negedge clk);
    resp_force = 1'b0;
    checks++; if (rd_addr.size() - rb !== 1) begin failures++; $display("FAIL rmm_fresh_read: got %0d reads want 1", rd_addr.size() - rb); end
    checks++; if (rd_addr[rb] !== 32'haaaaa000) begin failures++; $display("FAIL rmm_fresh_addr: got %h want aaaaa000", rd_addr[rb]); end
    resp_en = 1'b1;
    wait_enq(1, 20);
    checks++; if (enq_pc[eb] !== 32'haaaaa000) begin failures++; $display("FAIL rmm_pc: got %h want aaaaa000", enq_pc[eb]); end
    checks++; if (enq_instr[eb] !== ~32'haaaaa000) begin failures++; $display("FAIL rmm_instr: got %h want %h", enq_instr[eb], ~32'haaaaa000); end
    checks++; if (enq_order[eb] !== 64'd0) begin failures++; $display("FAIL rmm_order: got %0d want 0", enq_order[eb]); end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_stall();
    test_loop();
    test_evict();
    test_redirect_drain();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
